// File: rtl/sr_bp_pkg.sv
// Shared constants and helpers for the BTB branch predictor.
// Counter encodings are derived from the counter width so any CNT_W >= 1 works.
package sr_bp_pkg;

  localparam int unsigned PC_W = 32;

  // Weakly-taken: MSB set, all lower bits clear.
  function automatic int unsigned weak_taken(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

  // Weakly-not-taken: MSB clear, all lower bits set (0 when w == 1).
  function automatic int unsigned weak_not_taken(input int unsigned w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/sr_sat_counter.sv
// Combinational saturating up/down counter step; the output holds at the
// all-ones and zero bounds instead of wrapping.
module sr_sat_counter #(
  parameter int W = 2
) (
  input  logic [W-1:0] cnt_in,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt_out
);

  localparam logic [W-1:0] CNT_MAX = '1;

  always_comb begin
    cnt_out = cnt_in;
    if (inc && !dec) begin
      if (cnt_in != CNT_MAX) cnt_out = cnt_in + W'(1);
    end else if (dec && !inc) begin
      if (cnt_in != '0) cnt_out = cnt_in - W'(1);
    end
  end

endmodule

// File: rtl/sr_btb_predictor.sv
// Fetch-stage predictor: direct-mapped BTB with per-entry saturating direction
// counters, trained from execute, plus the redirect-tracking use_prediction flag.
module sr_btb_predictor
  import sr_bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] predicted_pc,
  output logic        predict_taken,
  output logic        use_prediction,
  input  logic        upd_vld,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  localparam logic [CNT_W-1:0] WEAK_T  = CNT_W'(weak_taken(CNT_W));
  localparam logic [CNT_W-1:0] WEAK_NT = CNT_W'(weak_not_taken(CNT_W));

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
    logic [CNT_W-1:0] cnt;
  } entry_t;

  localparam entry_t RESET_ENTRY = '{valid: 1'b0, tag: '0, target: '0, cnt: WEAK_NT};

  // Flop array rather than RAM: every valid bit must clear on reset.
  entry_t table_reg [ENTRIES];

  // ---------------- lookup ----------------
  logic [IDX_W-1:0] pc_idx;
  logic [TAG_W-1:0] pc_tag;
  entry_t           rd_entry;
  logic             rd_hit;
  logic [31:0]      pc_plus4;

  assign pc_idx   = pc[IDX_W+1:2];
  assign pc_tag   = pc[31:IDX_W+2];
  assign rd_entry = table_reg[pc_idx];
  assign rd_hit   = rd_entry.valid && (rd_entry.tag == pc_tag);
  assign pc_plus4 = pc + 32'd4;

  assign predict_taken = !rst && rd_hit && rd_entry.cnt[CNT_W-1];
  assign predicted_pc  = predict_taken ? rd_entry.target : pc_plus4;

  // ---------------- training ----------------
  logic [IDX_W-1:0]   upd_idx;
  logic [TAG_W-1:0]   upd_tag;
  entry_t             upd_entry;
  entry_t             upd_next;
  logic               upd_hit;
  logic               upd_we;
  logic [CNT_W-1:0]   cnt_trained;
  logic [ENTRIES-1:0] ent_we;

  assign upd_idx   = upd_pc[IDX_W+1:2];
  assign upd_tag   = upd_pc[31:IDX_W+2];
  assign upd_entry = table_reg[upd_idx];
  assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

  sr_sat_counter #(
    .W(CNT_W)
  ) u_sat_counter (
    .cnt_in (upd_entry.cnt),
    .inc    (upd_taken),
    .dec    (!upd_taken),
    .cnt_out(cnt_trained)
  );

  always_comb begin
    upd_next = upd_entry;
    upd_we   = 1'b0;
    if (upd_vld) begin
      if (upd_hit) begin
        upd_we       = 1'b1;
        upd_next.cnt = cnt_trained;
        if (upd_taken) upd_next.target = upd_target;
      end else if (upd_taken) begin
        // Taken miss steals the slot; not-taken misses are not worth an entry.
        upd_we          = 1'b1;
        upd_next.valid  = 1'b1;
        upd_next.tag    = upd_tag;
        upd_next.target = upd_target;
        upd_next.cnt    = WEAK_T;
      end
    end
  end

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry_we
    assign ent_we[gi] = upd_we && (upd_idx == IDX_W'(gi));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (rst) begin
        table_reg[i] <= RESET_ENTRY;
      end else if (ent_we[i]) begin
        table_reg[i] <= upd_next;
      end
    end
  end

  // ---------------- redirect tracking ----------------
  logic [31:0] last_address_reg;
  logic        pc_vld_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_address_reg <= '0;
      pc_vld_reg       <= 1'b0;
    end else begin
      last_address_reg <= use_prediction ? predicted_pc : pc;
      pc_vld_reg       <= 1'b1;
    end
  end

  assign use_prediction = !rst && pc_vld_reg && (last_address_reg == pc);

  logic unused_addr_bits;
  assign unused_addr_bits = ^{pc[1:0], upd_pc[1:0]};

endmodule
